// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the brainfuck core:
//   - op_t      : data-path op codes issued by the sequencer
//   - CH_*      : ASCII program bytes recognised by the decoder
//   - state_t   : sequencer FSM states
//   - decode_op : maps a program byte to a data-path op (valid=0 for non-ops)
// -----------------------------------------------------------------------------
package bf_pkg;

    typedef enum logic [2:0] {
        OP_RIGHT = 3'd0,
        OP_LEFT  = 3'd1,
        OP_INC   = 3'd2,
        OP_DEC   = 3'd3,
        OP_OUT   = 3'd4,
        OP_IN    = 3'd5
    } op_t;

    localparam logic [7:0] CH_INC        = 8'h2B; // '+'
    localparam logic [7:0] CH_DEC        = 8'h2D; // '-'
    localparam logic [7:0] CH_LEFT       = 8'h3C; // '<'
    localparam logic [7:0] CH_RIGHT      = 8'h3E; // '>'
    localparam logic [7:0] CH_OUT        = 8'h2E; // '.'
    localparam logic [7:0] CH_IN         = 8'h2C; // ','
    localparam logic [7:0] CH_LOOP_OPEN  = 8'h5B; // '['
    localparam logic [7:0] CH_LOOP_CLOSE = 8'h5D; // ']'
    localparam logic [7:0] CH_END        = 8'h00; // program terminator

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_SCAN_FWD_FETCH,
        ST_SCAN_FWD_CHECK,
        ST_SCAN_BWD_FETCH,
        ST_SCAN_BWD_CHECK,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic valid;
        op_t  op;
    } op_decode_t;

    function automatic op_decode_t decode_op(input logic [7:0] ch);
        op_decode_t d;
        d.valid = 1'b1;
        d.op    = OP_RIGHT;
        case (ch)
            CH_RIGHT: d.op = OP_RIGHT;
            CH_LEFT:  d.op = OP_LEFT;
            CH_INC:   d.op = OP_INC;
            CH_DEC:   d.op = OP_DEC;
            CH_OUT:   d.op = OP_OUT;
            CH_IN:    d.op = OP_IN;
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bf_loop_stack.sv
// -----------------------------------------------------------------------------
// bf_loop_stack
// Small LIFO of loop-start addresses for the sequencer.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the stack)
//   clear       : synchronous empty request (program restart)
//   push        : write push_data on top (ignored when full)
//   pop         : drop the top entry (ignored when empty)
//   push_data   : address to push
//   top         : current top entry (combinational, meaningful when !empty)
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module bf_loop_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_reg;
    logic [W-1:0]  entry_reg [DEPTH];

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + CW'(1);
        end else if (pop && !empty) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    // Entry storage carries no reset: occupancy is tracked by count_reg only.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && count_reg == CW'(i)) begin
                entry_reg[i] <= push_data;
            end
        end
    end

    // Top of stack is the entry just below the fill level.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_reg == CW'(i + 1)) begin
                top = entry_reg[i];
            end
        end
    end

endmodule

// File: rtl/bf_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bf_seq_ctrl
// Instruction sequencer for the brainfuck core. Owns the program counter,
// fetches bytes from a synchronous program ROM (1-cycle latency), resolves
// '[' / ']' control flow and issues data-path ops over valid/ready.
//
// Build option: define BF_LOOP_STACK_EN to resolve taken ']' through a loop
// stack (bf_loop_stack) instead of a backward scan.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : pulse; (re)starts execution at address 0 from IDLE or HALT
//   rom_addr    : program ROM address (= pc)
//   rom_data    : program byte, valid the cycle after rom_addr
//   cell_zero   : current data cell is zero (sampled in DECODE only)
//   op_valid/op : data-path op request and code, held until op_ready
//   op_ready    : data path accepts the op
//   busy        : not IDLE and not HALT
//   halted      : in HALT
//   error       : sticky bracket / stack / scan-bound error
// -----------------------------------------------------------------------------
module bf_seq_ctrl
    import bf_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 8,
    parameter int NEST_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              cell_zero,
    output logic              op_valid,
    output logic [2:0]        op,
    input  logic              op_ready,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam logic [ADDR_W-1:0] PC_MAX    = '1;
    localparam logic [NEST_W-1:0] DEPTH_MAX = '1;
    localparam logic [NEST_W-1:0] DEPTH_ONE = NEST_W'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [NEST_W-1:0] depth_reg, depth_next;
    op_t               op_reg, op_next;
    logic              error_reg, error_next;

    op_decode_t        dec;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_dec;
    logic              at_end;
    logic              at_start;

    assign dec      = decode_op(rom_data);
    assign pc_inc   = pc_reg + ADDR_W'(1);
    assign pc_dec   = pc_reg - ADDR_W'(1);
    assign at_end   = (pc_reg == PC_MAX);
    assign at_start = (pc_reg == '0);

`ifdef BF_LOOP_STACK_EN
    logic              stack_clear;
    logic              stack_push;
    logic              stack_pop;
    logic [ADDR_W-1:0] stack_top;
    logic              stack_full;
    logic              stack_empty;

    bf_loop_stack #(
        .DEPTH(STACK_DEPTH),
        .W    (ADDR_W)
    ) u_loop_stack (
        .clk      (clk),
        .reset    (reset),
        .clear    (stack_clear),
        .push     (stack_push),
        .pop      (stack_pop),
        .push_data(pc_reg),
        .top      (stack_top),
        .full     (stack_full),
        .empty    (stack_empty)
    );
`else
    localparam int unused_stack_depth = STACK_DEPTH;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            depth_reg <= '0;
            op_reg    <= OP_RIGHT;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            depth_reg <= depth_next;
            op_reg    <= op_next;
            error_reg <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        depth_next = depth_reg;
        op_next    = op_reg;
        error_next = error_reg;
`ifdef BF_LOOP_STACK_EN
        stack_clear = 1'b0;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
`endif
        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                    error_next = 1'b0;
`ifdef BF_LOOP_STACK_EN
                    stack_clear = 1'b1;
`endif
                end
            end

            ST_FETCH: state_next = ST_DECODE;

            ST_DECODE: begin
                if (dec.valid) begin
                    op_next    = dec.op;
                    state_next = ST_ISSUE;
                end else if (rom_data == CH_LOOP_OPEN) begin
                    if (cell_zero) begin
                        // Skip the loop body: scan forward for the matching ']'.
                        depth_next = DEPTH_ONE;
                        if (at_end) begin
                            error_next = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            pc_next    = pc_inc;
                            state_next = ST_SCAN_FWD_FETCH;
                        end
                    end else begin
`ifdef BF_LOOP_STACK_EN
                        if (stack_full) begin
                            error_next = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            stack_push = 1'b1;
                            if (at_end) begin
                                state_next = ST_HALT;
                            end else begin
                                pc_next    = pc_inc;
                                state_next = ST_FETCH;
                            end
                        end
`else
                        if (at_end) begin
                            state_next = ST_HALT;
                        end else begin
                            pc_next    = pc_inc;
                            state_next = ST_FETCH;
                        end
`endif
                    end
                end else if (rom_data == CH_LOOP_CLOSE) begin
                    if (!cell_zero) begin
`ifdef BF_LOOP_STACK_EN
                        // Loop again: the '[' entry stays on the stack.
                        if (stack_empty) begin
                            error_next = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            pc_next    = stack_top + ADDR_W'(1);
                            state_next = ST_FETCH;
                        end
`else
                        depth_next = DEPTH_ONE;
                        if (at_start) begin
                            error_next = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            pc_next    = pc_dec;
                            state_next = ST_SCAN_BWD_FETCH;
                        end
`endif
                    end else begin
`ifdef BF_LOOP_STACK_EN
                        if (stack_empty) begin
                            error_next = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            stack_pop = 1'b1;
                            if (at_end) begin
                                state_next = ST_HALT;
                            end else begin
                                pc_next    = pc_inc;
                                state_next = ST_FETCH;
                            end
                        end
`else
                        if (at_end) begin
                            state_next = ST_HALT;
                        end else begin
                            pc_next    = pc_inc;
                            state_next = ST_FETCH;
                        end
`endif
                    end
                end else if (rom_data == CH_END) begin
                    state_next = ST_HALT;
                end else begin
                    // Comment byte.
                    if (at_end) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_inc;
                        state_next = ST_FETCH;
                    end
                end
            end

            ST_ISSUE: begin
                if (op_ready) begin
                    if (at_end) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_inc;
                        state_next = ST_FETCH;
                    end
                end
            end

            ST_SCAN_FWD_FETCH: state_next = ST_SCAN_FWD_CHECK;

            ST_SCAN_FWD_CHECK: begin
                if (rom_data == CH_LOOP_OPEN && depth_reg == DEPTH_MAX) begin
                    error_next = 1'b1;
                    state_next = ST_HALT;
                end else if (rom_data == CH_LOOP_CLOSE && depth_reg == DEPTH_ONE) begin
                    // Matching ']' found: resume just after it.
                    depth_next = '0;
                    if (at_end) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_inc;
                        state_next = ST_FETCH;
                    end
                end else begin
                    if (rom_data == CH_LOOP_OPEN) begin
                        depth_next = depth_reg + DEPTH_ONE;
                    end else if (rom_data == CH_LOOP_CLOSE) begin
                        depth_next = depth_reg - DEPTH_ONE;
                    end
                    if (at_end) begin
                        error_next = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_inc;
                        state_next = ST_SCAN_FWD_FETCH;
                    end
                end
            end

            ST_SCAN_BWD_FETCH: state_next = ST_SCAN_BWD_CHECK;

            ST_SCAN_BWD_CHECK: begin
                if (rom_data == CH_LOOP_CLOSE && depth_reg == DEPTH_MAX) begin
                    error_next = 1'b1;
                    state_next = ST_HALT;
                end else if (rom_data == CH_LOOP_OPEN && depth_reg == DEPTH_ONE) begin
                    // Matching '[' found: re-enter the body just after it.
                    depth_next = '0;
                    if (at_end) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_inc;
                        state_next = ST_FETCH;
                    end
                end else begin
                    if (rom_data == CH_LOOP_CLOSE) begin
                        depth_next = depth_reg + DEPTH_ONE;
                    end else if (rom_data == CH_LOOP_OPEN) begin
                        depth_next = depth_reg - DEPTH_ONE;
                    end
                    if (at_start) begin
                        error_next = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_dec;
                        state_next = ST_SCAN_BWD_FETCH;
                    end
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign rom_addr = pc_reg;
    assign op_valid = (state_reg == ST_ISSUE);
    assign op       = op_reg;
    assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign halted   = (state_reg == ST_HALT);
    assign error    = error_reg;

endmodule
